lsu: RTL
========

LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL provide parameter DMEM_WORDS, default 512, data-memory depth in 32-bit words (2 KiB).
REQ-002 SHALL provide i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide i_lsu_addr  input  32  byte address (ALU result).
REQ-005 SHALL provide i_st_data  input  32  store data (rs2).
REQ-006 SHALL provide i_lsu_wren  input  1  1 = store, 0 = load/idle.
REQ-007 SHALL provide i_lsu_op  input  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 SHALL provide o_ld_data  output  32  load result, sign/zero-extended.
REQ-009 SHALL provide o_misaligned  output  1  access not naturally aligned for size.
REQ-010 SHALL provide o_io_ledr  output  32  red LED register.
REQ-011 SHALL provide o_io_ledg  output  32  green LED register.
REQ-012 SHALL provide o_io_hex0 .. o_io_hex7  output  7 each  seven-segment registers.
REQ-013 SHALL provide o_io_lcd  output  32  LCD control register.
REQ-014 SHALL provide i_io_sw  input  32  switches, asynchronous to i_clk.

Function
REQ-015 Memory map SHALL be: 0x0000_0000..0x0000_07FF DMEM; 0x7000 LEDR; 0x7010 LEDG; 0x7020 HEX0-3 (byte n = HEXn, bits [6:0]); 0x7024 HEX4-7; 0x7030 LCD; 0x7800 SW (read-only); all else unmapped.
REQ-016 Loads SHALL be combinational: o_ld_data valid in the same cycle as address/op (single-cycle core).
REQ-017 Stores SHALL commit on the rising edge when i_lsu_wren=1, o_misaligned=0, target mapped and writable.
REQ-018 Store width SHALL follow i_lsu_op[1:0]: SB writes addr[1:0] byte lane, SH writes lane pair addr[1], SW all four lanes; other lanes unchanged.
REQ-019 Load SHALL select lane by addr[1:0]; B/H sign-extend bit 7/15; BU/HU zero-extend; W passes 32 bits.
REQ-020 o_misaligned SHALL be 1 for H/HU with addr[0]=1 and W with addr[1:0]!=00; misaligned store SHALL be dropped, misaligned load SHALL return 0.
REQ-021 Unmapped load SHALL return 0; unmapped or SW-region store SHALL be ignored.
REQ-022 i_io_sw SHALL pass a 2-flop synchronizer; SW reads return synchronized value (2-cycle latency from pin).
REQ-023 Store followed next cycle by load of the same address SHALL return the new data (no forwarding needed; write at edge).
REQ-024 Reserved i_lsu_op codes (011, 11x) SHALL behave as W for both loads and stores.
REQ-025 Peripheral outputs SHALL be driven directly from their registers (glitch-free).

Reset
REQ-026 On i_rst_n=0 all peripheral registers and synchronizer flops SHALL clear to 0 immediately, independent of i_clk.
REQ-027 DMEM contents SHALL NOT be reset; a store coinciding with reset assertion SHALL be discarded.
REQ-028 First store SHALL be accepted on the first rising edge after i_rst_n deasserts.

Structure
REQ-029 Package lsu_pkg SHALL hold the address-map constants, DMEM_WORDS default and the funct3 load/store-size enum.
REQ-030 DMEM SHALL be a sub-module dmem (DMEM_WORDS x 32, 4 byte-enables, sync write, async read).

Verification
REQ-031 SW 0x1234_5678 @0x100, then LB/LBU @0x103 -> 0x0000_0012; LH @0x102 -> 0x0000_1234; LW @0x100 -> 0x1234_5678.
REQ-032 SB 0xFF @0x101 over 0 word, then LB @0x101 -> 0xFFFF_FFFF, LBU -> 0x0000_00FF, LW @0x100 -> 0x0000_FF00.
REQ-033 SH @0x101 / SW @0x102 -> o_misaligned=1, memory unchanged; LW @0x102 -> 0, o_misaligned=1.
REQ-034 SW 0x0000_0079 @0x7020 -> o_io_hex0=0x79 next edge, hex1-3=0; SW 0xAA @0x7000 -> o_io_ledr=0xAA.
REQ-035 Drive i_io_sw=0xDEAD_BEEF -> LW @0x7800 returns it after 2 edges; SW to 0x7800 and 0x5000 ignored, LW 0x5000 -> 0.
REQ-036 Assert i_rst_n=0 mid-cycle after LED writes -> LED/HEX/LCD outputs 0 before next edge; DMEM word @0x100 retained.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: address map, memory depth,
// access-size encoding and the lane steering helpers used on both the
// store and load paths.
package lsu_pkg;

    localparam int DMEM_WORDS_DEF = 512;

    // Peripheral register byte addresses (word aligned)
    localparam logic [31:0] ADDR_LEDR   = 32'h0000_7000;
    localparam logic [31:0] ADDR_LEDG   = 32'h0000_7010;
    localparam logic [31:0] ADDR_HEX_LO = 32'h0000_7020;
    localparam logic [31:0] ADDR_HEX_HI = 32'h0000_7024;
    localparam logic [31:0] ADDR_LCD    = 32'h0000_7030;
    localparam logic [31:0] ADDR_SW     = 32'h0000_7800;

    // funct3 load/store encodings
    typedef enum logic [2:0] {
        LSU_B  = 3'b000,
        LSU_H  = 3'b001,
        LSU_W  = 3'b010,
        LSU_BU = 3'b100,
        LSU_HU = 3'b101
    } lsu_op_e;

    // Access width after folding reserved codes onto word
    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } lsu_size_e;

    // Reserved funct3 codes behave as a word access
    function automatic lsu_size_e op_size(input logic [2:0] op);
        lsu_size_e sz;
        case (op)
            LSU_B, LSU_BU: sz = SZ_B;
            LSU_H, LSU_HU: sz = SZ_H;
            default:       sz = SZ_W;
        endcase
        return sz;
    endfunction

    function automatic logic is_misaligned(input lsu_size_e sz, input logic [1:0] a);
        logic m;
        case (sz)
            SZ_B:    m = 1'b0;
            SZ_H:    m = a[0];
            default: m = (a != 2'b00);
        endcase
        return m;
    endfunction

    function automatic logic [3:0] byte_en(input lsu_size_e sz, input logic [1:0] a);
        logic [3:0] be;
        case (sz)
            SZ_B:    be = 4'b0001 << a;
            SZ_H:    be = a[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate narrow store data onto every lane; byte enables pick the lane
    function automatic logic [31:0] store_lanes(input lsu_size_e sz, input logic [31:0] d);
        logic [31:0] w;
        case (sz)
            SZ_B:    w = {4{d[7:0]}};
            SZ_H:    w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    // Byte-lane merge of new data into an existing word
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return r;
    endfunction

    // Lane select and sign/zero extension of a loaded word
    function automatic logic [31:0] load_extract(input logic [2:0]  op,
                                                 input logic [1:0]  a,
                                                 input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic        uns;
        logic [31:0] r;
        uns = op[2] & ~op[1];
        case (a)
            2'b00:   b = w[7:0];
            2'b01:   b = w[15:8];
            2'b10:   b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (op_size(op))
            SZ_B:    r = uns ? {24'h00_0000, b} : {{24{b[7]}}, b};
            SZ_H:    r = uns ? {16'h0000, h}    : {{16{h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_dmem.sv
// Data memory: word-organised array with four byte enables, synchronous
// write and asynchronous (combinational) read. Contents are not reset.
module dmem #(
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_r [DEPTH];

    // Byte-enabled write on the rising edge
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem_r[addr];

endmodule

// File: rtl/lsu.sv
// Load/store unit for a single-cycle core: decodes the address map,
// steers byte lanes, owns the LED/HEX/LCD peripheral registers and the
// switch synchronizer, and instantiates the data memory.
module lsu
    import lsu_pkg::*;
#(
    parameter int DMEM_WORDS = DMEM_WORDS_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_lsu_addr,
    input  logic [31:0] i_st_data,
    input  logic        i_lsu_wren,
    input  logic [2:0]  i_lsu_op,
    output logic [31:0] o_ld_data,
    output logic        o_misaligned,
    output logic [31:0] o_io_ledr,
    output logic [31:0] o_io_ledg,
    output logic [6:0]  o_io_hex0,
    output logic [6:0]  o_io_hex1,
    output logic [6:0]  o_io_hex2,
    output logic [6:0]  o_io_hex3,
    output logic [6:0]  o_io_hex4,
    output logic [6:0]  o_io_hex5,
    output logic [6:0]  o_io_hex6,
    output logic [6:0]  o_io_hex7,
    output logic [31:0] o_io_lcd,
    input  logic [31:0] i_io_sw
);

    localparam int          DMEM_AW    = $clog2(DMEM_WORDS);
    localparam logic [31:0] DMEM_BYTES = 32'(DMEM_WORDS * 4);

    lsu_size_e   size_s;
    logic        misaligned_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s;
    logic        store_ok_s;

    logic        hit_dmem_s;
    logic        hit_ledr_s;
    logic        hit_ledg_s;
    logic        hit_hex_lo_s;
    logic        hit_hex_hi_s;
    logic        hit_lcd_s;
    logic        hit_sw_s;

    logic        dmem_we_s;
    logic [31:0] dmem_rdata_s;
    logic [31:0] rd_word_s;

    logic [31:0] ledr_r;
    logic [31:0] ledg_r;
    logic [31:0] lcd_r;
    logic [6:0]  hex_r [8];
    logic [31:0] sw_meta_r;
    logic [31:0] sw_sync_r;

    // Access size, alignment and lane steering for the current request
    always_comb begin
        size_s       = op_size(i_lsu_op);
        misaligned_s = is_misaligned(size_s, i_lsu_addr[1:0]);
        be_s         = byte_en(size_s, i_lsu_addr[1:0]);
        wdata_s      = store_lanes(size_s, i_st_data);
        store_ok_s   = i_lsu_wren & ~misaligned_s;
    end

    // Address map decode; peripherals match on the full word address
    always_comb begin
        hit_dmem_s   = (i_lsu_addr < DMEM_BYTES);
        hit_ledr_s   = (i_lsu_addr[31:2] == ADDR_LEDR[31:2]);
        hit_ledg_s   = (i_lsu_addr[31:2] == ADDR_LEDG[31:2]);
        hit_hex_lo_s = (i_lsu_addr[31:2] == ADDR_HEX_LO[31:2]);
        hit_hex_hi_s = (i_lsu_addr[31:2] == ADDR_HEX_HI[31:2]);
        hit_lcd_s    = (i_lsu_addr[31:2] == ADDR_LCD[31:2]);
        hit_sw_s     = (i_lsu_addr[31:2] == ADDR_SW[31:2]);
    end

    // Memory has no reset, so a store overlapping reset is blocked here
    assign dmem_we_s = store_ok_s & hit_dmem_s & i_rst_n;

    dmem #(
        .DEPTH (DMEM_WORDS)
    ) u_dmem (
        .clk   (i_clk),
        .we    (dmem_we_s),
        .be    (be_s),
        .addr  (i_lsu_addr[DMEM_AW+1:2]),
        .wdata (wdata_s),
        .rdata (dmem_rdata_s)
    );

    // Peripheral register writes; reset clears them without a clock
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ledr_r <= 32'h0000_0000;
            ledg_r <= 32'h0000_0000;
            lcd_r  <= 32'h0000_0000;
            for (int n = 0; n < 8; n++) begin
                hex_r[n] <= 7'h00;
            end
        end else if (store_ok_s) begin
            if (hit_ledr_s) begin
                ledr_r <= merge_bytes(ledr_r, wdata_s, be_s);
            end else if (hit_ledg_s) begin
                ledg_r <= merge_bytes(ledg_r, wdata_s, be_s);
            end else if (hit_lcd_s) begin
                lcd_r <= merge_bytes(lcd_r, wdata_s, be_s);
            end else if (hit_hex_lo_s) begin
                for (int n = 0; n < 4; n++) begin
                    if (be_s[n]) begin
                        hex_r[n] <= wdata_s[8*n +: 7];
                    end
                end
            end else if (hit_hex_hi_s) begin
                for (int n = 0; n < 4; n++) begin
                    if (be_s[n]) begin
                        hex_r[n+4] <= wdata_s[8*n +: 7];
                    end
                end
            end else begin
                ledr_r <= ledr_r;
            end
        end else begin
            ledr_r <= ledr_r;
        end
    end

    // Two-flop synchronizer for the asynchronous switch inputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sw_meta_r <= 32'h0000_0000;
            sw_sync_r <= 32'h0000_0000;
        end else begin
            sw_meta_r <= i_io_sw;
            sw_sync_r <= sw_meta_r;
        end
    end

    // Read-word selection by region; unmapped addresses read as zero
    always_comb begin
        rd_word_s = 32'h0000_0000;
        if (hit_dmem_s) begin
            rd_word_s = dmem_rdata_s;
        end else if (hit_ledr_s) begin
            rd_word_s = ledr_r;
        end else if (hit_ledg_s) begin
            rd_word_s = ledg_r;
        end else if (hit_hex_lo_s) begin
            rd_word_s = {1'b0, hex_r[3], 1'b0, hex_r[2], 1'b0, hex_r[1], 1'b0, hex_r[0]};
        end else if (hit_hex_hi_s) begin
            rd_word_s = {1'b0, hex_r[7], 1'b0, hex_r[6], 1'b0, hex_r[5], 1'b0, hex_r[4]};
        end else if (hit_lcd_s) begin
            rd_word_s = lcd_r;
        end else if (hit_sw_s) begin
            rd_word_s = sw_sync_r;
        end else begin
            rd_word_s = 32'h0000_0000;
        end
    end

    // Load result: lane extract, forced to zero on a misaligned access
    always_comb begin
        o_ld_data = 32'h0000_0000;
        if (misaligned_s) begin
            o_ld_data = 32'h0000_0000;
        end else begin
            o_ld_data = load_extract(i_lsu_op, i_lsu_addr[1:0], rd_word_s);
        end
    end

    assign o_misaligned = misaligned_s;
    assign o_io_ledr    = ledr_r;
    assign o_io_ledg    = ledg_r;
    assign o_io_lcd     = lcd_r;
    assign o_io_hex0    = hex_r[0];
    assign o_io_hex1    = hex_r[1];
    assign o_io_hex2    = hex_r[2];
    assign o_io_hex3    = hex_r[3];
    assign o_io_hex4    = hex_r[4];
    assign o_io_hex5    = hex_r[5];
    assign o_io_hex6    = hex_r[6];
    assign o_io_hex7    = hex_r[7];

endmodule
